// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC engine family: FSM state encoding
// and the polynomial/seed pairs of the CRC-8 variants the engine is built for.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EMIT  = 2'd2
  } crc_state_e;

  // Tap masks are in the right-shifting (reflected) form used by crc_lfsr_step.
  localparam logic [7:0] CRC8_POLY       = 8'h44;
  localparam logic [7:0] CRC8_SEED       = 8'hD8;
  localparam logic [7:0] CRC8_MAXIM_POLY = 8'h8C;
  localparam logic [7:0] CRC8_MAXIM_SEED = 8'h00;
  localparam logic [7:0] CRC8_ROHC_POLY  = 8'hE0;
  localparam logic [7:0] CRC8_ROHC_SEED  = 8'hFF;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit combinational LFSR step: the feedback bit enters at the MSB and is
// XORed into every lower position whose POLY bit is set.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC8_POLY)
) (
  input  logic [WIDTH-1:0] L,
  input  logic             d,
  output logic [WIDTH-1:0] next
);

  logic w_fb;

  always_comb begin
    w_fb = L[0] ^ d;
    next = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      next[i] = L[i+1] ^ (POLY[i] & w_fb);
    end
    next[WIDTH-1] = w_fb;
  end

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine: absorbs a frame while Active is high, then either
// shifts the CRC out LSB-first (generate) or reports whether the residue is zero (check).
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC8_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(CRC8_SEED)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Data,
  input  logic             Active,
  input  logic             Mode,
  output logic             CRC,
  output logic             valid,
  output logic [WIDTH-1:0] crc_par,
  output logic             crc_ok,
  output logic             chk_vld,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  crc_state_e       r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic             r_crc;
  logic             r_valid;
  logic [WIDTH-1:0] r_crcPar;
  logic             r_crcOk;
  logic             r_chkVld;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_modeQ;

  crc_state_e       w_state;
  logic [WIDTH-1:0] w_lfsr;
  logic             w_crc;
  logic             w_valid;
  logic [WIDTH-1:0] w_crcPar;
  logic             w_crcOk;
  logic             w_chkVld;
  logic [CNT_W-1:0] w_cnt;
  logic             w_modeQ;
  logic [WIDTH-1:0] w_stepIn;
  logic [WIDTH-1:0] w_stepOut;

  // Outside SHIFT every absorbed bit starts a new frame, so it steps from SEED.
  assign w_stepIn = (r_state == SHIFT) ? r_lfsr : SEED;

  crc_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .L    (w_stepIn),
    .d    (Data),
    .next (w_stepOut)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_lfsr   <= SEED;
      r_crc    <= 1'b0;
      r_valid  <= 1'b0;
      r_crcPar <= '0;
      r_crcOk  <= 1'b0;
      r_chkVld <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_modeQ  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_lfsr   <= w_lfsr;
      r_crc    <= w_crc;
      r_valid  <= w_valid;
      r_crcPar <= w_crcPar;
      r_crcOk  <= w_crcOk;
      r_chkVld <= w_chkVld;
      r_busy   <= (w_state != IDLE);
      r_cnt    <= w_cnt;
      r_modeQ  <= w_modeQ;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_lfsr   = r_lfsr;
    w_crc    = r_crc;
    w_valid  = r_valid;
    w_crcPar = r_crcPar;
    w_crcOk  = r_crcOk;
    w_chkVld = 1'b0;
    w_cnt    = r_cnt;
    w_modeQ  = r_modeQ;
    unique case (r_state)
      IDLE: begin
        if (Active) begin
          w_lfsr  = w_stepOut;
          w_modeQ = Mode;
          w_state = SHIFT;
        end
      end
      SHIFT: begin
        if (Active) begin
          w_lfsr = w_stepOut;
        end else if (!r_modeQ) begin
          // First CRC bit leaves on the same edge that ends the frame.
          w_crc    = r_lfsr[0];
          w_lfsr   = {1'b0, r_lfsr[WIDTH-1:1]};
          w_crcPar = r_lfsr;
          w_valid  = 1'b1;
          w_cnt    = CNT_W'(1);
          w_state  = EMIT;
        end else begin
          w_crcOk  = (r_lfsr == '0);
          w_chkVld = 1'b1;
          w_state  = IDLE;
        end
      end
      EMIT: begin
        if (Active) begin
          w_valid = 1'b0;
          w_cnt   = '0;
          w_lfsr  = w_stepOut;
          w_modeQ = Mode;
          w_state = SHIFT;
        end else if (r_cnt == CNT_W'(WIDTH)) begin
          w_valid = 1'b0;
          w_cnt   = '0;
          w_state = IDLE;
        end else begin
          w_crc  = r_lfsr[0];
          w_lfsr = {1'b0, r_lfsr[WIDTH-1:1]};
          w_cnt  = r_cnt + CNT_W'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign CRC     = r_crc;
  assign valid   = r_valid;
  assign crc_par = r_crcPar;
  assign crc_ok  = r_crcOk;
  assign chk_vld = r_chkVld;
  assign busy    = r_busy;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Self-checking bench: an 8-bit default engine and a 16-bit engine share inputs;
// results are compared against a table of known frames and an arithmetic CRC model.
module tb_crc_serial_engine;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Data;
  logic        Active;
  logic        Mode;

  logic        crc8, valid8, ok8, chk8, busy8;
  logic [7:0]  par8;
  logic        crc16, valid16, ok16, chk16, busy16;
  logic [15:0] par16;

  int          nCompared  = 0;
  int          nMismatched = 0;
  logic [7:0]  lastPar8;
  logic [15:0] lastPar16;

  crc_serial_engine dut8 (
    .CLK     (CLK),
    .RST     (RST),
    .Data    (Data),
    .Active  (Active),
    .Mode    (Mode),
    .CRC     (crc8),
    .valid   (valid8),
    .crc_par (par8),
    .crc_ok  (ok8),
    .chk_vld (chk8),
    .busy    (busy8)
  );

  crc_serial_engine #(
    .WIDTH (16),
    .POLY  (16'h8408),
    .SEED  (16'hFFFF)
  ) dut16 (
    .CLK     (CLK),
    .RST     (RST),
    .Data    (Data),
    .Active  (Active),
    .Mode    (Mode),
    .CRC     (crc16),
    .valid   (valid16),
    .crc_par (par16),
    .crc_ok  (ok16),
    .chk_vld (chk16),
    .busy    (busy16)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        mode;
    int          nBits;
    logic [63:0] bits;
    logic [7:0]  expPar;
    logic        expOk;
  } vec_t;

  // Reflected CRC in plain shift/xor arithmetic; bit k of 'bits' is the k-th frame bit.
  function automatic logic [31:0] modelCrc(input int w, input logic [31:0] poly,
                                           input logic [31:0] seed,
                                           input logic [63:0] bits, input int n);
    logic [31:0] mask;
    logic [31:0] fbMask;
    logic [31:0] r;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    fbMask = (poly & (mask >> 1)) | (32'd1 << (w - 1));
    r      = seed & mask;
    for (int i = 0; i < n; i++) begin
      if (r[0] ^ bits[i]) r = (r >> 1) ^ fbMask;
      else                r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] model8(input logic [63:0] bits, input int n);
    logic [31:0] r;
    r = modelCrc(8, 32'h44, 32'hD8, bits, n);
    return r[7:0];
  endfunction

  function automatic logic [15:0] model16(input logic [63:0] bits, input int n);
    logic [31:0] r;
    r = modelCrc(16, 32'h8408, 32'hFFFF, bits, n);
    return r[15:0];
  endfunction

  task automatic applyStimulus(input logic d, input logic a, input logic m);
    Data   = d;
    Active = a;
    Mode   = m;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Drives one frame then follows the emission or check result on both engines.
  task automatic runFrame(input logic mode, input int n, input logic [63:0] bits,
                          input logic [7:0] expPar8, input logic expOk8);
    logic [15:0] expPar16;
    logic        expOk16;
    expPar16 = model16(bits, n);
    expOk16  = (expPar16 == 16'h0);
    for (int i = 0; i < n; i++) begin
      applyStimulus(bits[i], 1'b1, (i == 0) ? mode : rbit());
      checkOutput("busy8_frame", busy8, 1);
      checkOutput("valid8_frame", valid8, 0);
    end
    applyStimulus(rbit(), 1'b0, rbit());
    if (!mode) begin
      for (int k = 0; k < 16; k++) begin
        if (k < 8) begin
          checkOutput("valid8", valid8, 1);
          checkOutput("crc8_bit", crc8, expPar8[k]);
          checkOutput("busy8_emit", busy8, 1);
          checkOutput("par8", par8, expPar8);
        end else begin
          checkOutput("valid8_end", valid8, 0);
          checkOutput("busy8_end", busy8, 0);
        end
        checkOutput("valid16", valid16, 1);
        checkOutput("crc16_bit", crc16, expPar16[k]);
        checkOutput("par16", par16, expPar16);
        applyStimulus(rbit(), 1'b0, rbit());
      end
      checkOutput("valid16_end", valid16, 0);
      checkOutput("busy16_end", busy16, 0);
      checkOutput("crc8_hold", crc8, expPar8[7]);
      checkOutput("crc16_hold", crc16, expPar16[15]);
      lastPar8  = expPar8;
      lastPar16 = expPar16;
    end else begin
      checkOutput("chk8", chk8, 1);
      checkOutput("ok8", ok8, expOk8);
      checkOutput("chk16", chk16, 1);
      checkOutput("ok16", ok16, expOk16);
      checkOutput("busy8_chk", busy8, 0);
      checkOutput("valid8_chk", valid8, 0);
      checkOutput("par8_keep", par8, lastPar8);
      checkOutput("par16_keep", par16, lastPar16);
      applyStimulus(rbit(), 1'b0, rbit());
      checkOutput("chk8_pulse", chk8, 0);
      checkOutput("ok8_hold", ok8, expOk8);
    end
  endtask

  initial begin
    vec_t        vecs[5];
    logic [63:0] bits;
    logic [7:0]  c8;
    int          n;

    vecs[0] = '{mode: 1'b0, nBits: 1, bits: 64'h0,   expPar: 8'h6C, expOk: 1'b0};
    vecs[1] = '{mode: 1'b0, nBits: 1, bits: 64'h1,   expPar: 8'hA8, expOk: 1'b0};
    vecs[2] = '{mode: 1'b0, nBits: 1, bits: 64'h1,   expPar: 8'hA8, expOk: 1'b0};
    vecs[3] = '{mode: 1'b1, nBits: 9, bits: 64'h0D8, expPar: 8'h00, expOk: 1'b1};
    vecs[4] = '{mode: 1'b1, nBits: 9, bits: 64'h1D8, expPar: 8'h00, expOk: 1'b0};

    RST = 1'b0; Data = 1'b0; Active = 1'b0; Mode = 1'b0;
    lastPar8 = 8'h0; lastPar16 = 16'h0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_valid8", valid8, 0);
    checkOutput("rst_crc8", crc8, 0);
    checkOutput("rst_par8", par8, 0);
    checkOutput("rst_ok8", ok8, 0);
    checkOutput("rst_chk8", chk8, 0);
    checkOutput("rst_busy8", busy8, 0);
    checkOutput("rst_par16", par16, 0);
    checkOutput("rst_busy16", busy16, 0);
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    for (int v = 0; v < 5; v++) begin
      runFrame(vecs[v].mode, vecs[v].nBits, vecs[v].bits, vecs[v].expPar, vecs[v].expOk);
    end

    // Abort: a new frame raised on the third valid cycle of an emission.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_valid_pre", valid8, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("abort_valid_drop", valid8, 0);
    checkOutput("abort_par_keep", par8, 8'hA8);
    checkOutput("abort_busy", busy8, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      checkOutput("abort_valid", valid8, 1);
      checkOutput("abort_crc_bit", crc8, 32'(8'h6C >> k) & 32'h1);
      checkOutput("abort_par_new", par8, 8'h6C);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b0);
    lastPar8  = 8'h6C;
    lastPar16 = model16(64'h0, 1);
    checkOutput("abort_par16", par16, lastPar16);

    // Asynchronous reset on the fourth valid cycle of an emission.
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_mid_crc_pre", crc8, 1);
    #2 RST = 1'b0;
    #1;
    checkOutput("rst_mid_valid", valid8, 0);
    checkOutput("rst_mid_crc", crc8, 0);
    checkOutput("rst_mid_busy", busy8, 0);
    checkOutput("rst_mid_par", par8, 0);
    checkOutput("rst_mid_busy16", busy16, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    lastPar8 = 8'h0; lastPar16 = 16'h0;
    runFrame(vecs[0].mode, vecs[0].nBits, vecs[0].bits, vecs[0].expPar, vecs[0].expOk);

    // 8-bit all-zero frame, mainly for the 16-bit engine against the model.
    runFrame(1'b0, 8, 64'h0, model8(64'h0, 8), 1'b0);

    for (int r = 0; r < 12; r++) begin
      n    = $urandom_range(1, 32);
      bits = {32'($urandom), 32'($urandom)} & ((64'd1 << n) - 64'd1);
      runFrame(1'b0, n, bits, model8(bits, n), 1'b0);
    end

    for (int r = 0; r < 12; r++) begin
      n    = $urandom_range(1, 16);
      bits = {32'($urandom), 32'($urandom)} & ((64'd1 << n) - 64'd1);
      c8   = model8(bits, n);
      bits = bits | (64'(c8) << n);
      if ($urandom_range(0, 2) == 0) bits[$urandom_range(0, n + 7)] ^= 1'b1;
      runFrame(1'b1, n + 8, bits, 8'h0, model8(bits, n + 8) == 8'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
Parametrised serial CRC engine using an LFSR with configurable width, polynomial and seed.
- Generate mode: absorbs a bit-serial frame while Active is high, then shifts the CRC out LSB-first with valid.
- Check mode: absorbs frame plus received CRC and flags crc_ok.
- Reloads SEED at every frame start and exposes the final CRC in parallel.
- Sits between the serial framer and the line encoder (TX) or deframer (RX).

Parameters:
WIDTH, 8, CRC/LFSR width (2..32).
POLY, 8'h44, tap mask; bit i set means Feedback is XORed into next[i] (i < WIDTH-1).
SEED, 8'hD8, LFSR value loaded at reset and at every frame start.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous, active-low reset.
Data  input  1  serial frame bit, sampled when Active=1.
Active  input  1  frame-bit qualifier; high for every frame bit, low ends the frame.
Mode  input  1  0 = generate, 1 = check; sampled on the frame's first Active cycle only.
CRC  output  1  serial CRC bit, LSB first.
valid  output  1  CRC bit valid.
crc_par  output  WIDTH  final CRC of the last generate frame.
crc_ok  output  1  check result; meaningful while chk_vld=1.
chk_vld  output  1  one-cycle pulse, check result ready.
busy  output  1  high in SHIFT or EMIT.

Behaviour:
- Reset values (RST low, async): state IDLE, LFSR=SEED, CRC=0, valid=0, crc_par=0, crc_ok=0, chk_vld=0, busy=0, cnt=0, mode_q=0.
- step(L,d): F = L[0]^d; next[WIDTH-1] = F; next[i] = L[i+1] ^ (POLY[i] & F) for i < WIDTH-1.
- Default parameters reproduce the existing 8-bit CRC generator.
- chk_vld defaults to 0 every cycle unless set below.
- IDLE:
  - LFSR holds.
  - Active=1: LFSR <= step(SEED, Data); mode_q <= Mode; go to SHIFT. The seed reload is implicit; the first bit is never lost.
- SHIFT:
  - Active=1: LFSR <= step(LFSR, Data).
  - Active=0, mode_q=0: on the same edge, CRC <= LFSR[0]; LFSR <= {1'b0, LFSR[WIDTH-1:1]}; crc_par <= LFSR; valid <= 1; cnt <= 1; go to EMIT.
  - Active=0, mode_q=1: crc_ok <= (LFSR == 0); chk_vld <= 1; go to IDLE.
- EMIT:
  - If cnt == WIDTH: valid <= 0; cnt <= 0; go to IDLE.
  - Otherwise: CRC <= LFSR[0]; shift right with zero fill; cnt <= cnt + 1.
  - Net effect: valid is high for exactly WIDTH consecutive cycles.
- Latency: first CRC bit appears on the edge that samples Active low.
- Active=1 during EMIT: emission aborts; valid <= 0; the new frame starts as from IDLE (step(SEED, Data)) with Mode re-sampled. crc_par keeps the aborted frame's value.
- A one-bit frame (Active high for one cycle) is legal.
- Back-to-back frames in check mode need one Active-low cycle between them.
- busy = (state != IDLE), registered.
- Mode changes outside the first Active cycle have no effect.
- Reset mid-frame or mid-emission returns all state to reset values immediately; the frame is discarded.
- cnt is $clog2(WIDTH)+1 bits wide; no wrap is possible.
- CRC output holds its last value when valid=0.

Decomposition:
- Package crc_pkg:
  - state encoding constants IDLE=2'd0, SHIFT=2'd1, EMIT=2'd2;
  - named POLY/SEED constants for the supported CRC-8 variants.
- Sub-module crc_lfsr_step: combinational one-bit step, parameters WIDTH and POLY, ports L, d -> next.
  - Reused by the future parallel CRC engine.

Test Plan:
- Reset, then Active=1 for 1 cycle with Data=0, Mode=0 -> valid high for 8 cycles; CRC sequence 0,0,1,1,0,1,1,0; crc_par=8'h6C.
- Same with Data=1 -> crc_par=8'hA8; CRC sequence 0,0,0,1,0,1,0,1; a second identical frame gives the same result (seed reload).
- Mode=1, feed 9 bits 0,0,0,1,1,0,1,1,0 -> chk_vld pulse with crc_ok=1; flip the last bit -> crc_ok=0.
- Generate frame, then raise Active at the 3rd valid cycle with Data=0 -> valid drops next edge; new frame emits 8'h6C; crc_par holds until the new emission starts.
- Assert RST at the 4th valid cycle -> valid=0, CRC=0, busy=0 immediately; the next frame behaves as the first test.
- WIDTH=16, POLY=16'h8408, SEED=16'hFFFF, 8-bit frame 0x00 -> valid high for 16 cycles; a golden-model compare matches crc_par.
